// File: rtl/color_pkg.sv
// Shared constants, serializer state encoding and report-message byte lookup
// for the colour report transmitter.
package color_pkg;

   localparam int MSG_LEN = 12;

   localparam logic [7:0] ASCII_S    = 8'h53;
   localparam logic [7:0] ASCII_I    = 8'h49;
   localparam logic [7:0] ASCII_M    = 8'h4D;
   localparam logic [7:0] ASCII_DASH = 8'h2D;
   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_QM   = 8'h3F;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Report layout: "SI-SIM" <unit> "-" <letter> "-#" LF
   function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                           input logic [7:0] letter,
                                           input logic [7:0] unit);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         4'd0:    b = ASCII_S;
         4'd1:    b = ASCII_I;
         4'd2:    b = ASCII_DASH;
         4'd3:    b = ASCII_S;
         4'd4:    b = ASCII_I;
         4'd5:    b = ASCII_M;
         4'd6:    b = unit;
         4'd7:    b = ASCII_DASH;
         4'd8:    b = letter;
         4'd9:    b = ASCII_DASH;
         4'd10:   b = ASCII_HASH;
         4'd11:   b = ASCII_LF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/color_debounce.sv
// Debounces the sensor colour code and emits one registered strobe per stable
// episode: confirm for a reportable colour, idle for the none/white code.
module color_debounce
   import color_pkg::*;
#(
   parameter int CODE_W     = 2,
   parameter int DEBOUNCE   = 5,
   parameter int NUM_COLORS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] cd_input,
   output logic              confirm,
   output logic [CODE_W-1:0] code,
   output logic              idle
);

   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]     DB_MAX  = CW'(DEBOUNCE);
   localparam logic [CODE_W-1:0] NC_CODE = CODE_W'(NUM_COLORS);

   logic [CODE_W-1:0] prev_q, prev_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              confirm_q, confirm_d;
   logic              idle_q, idle_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              changed;
   logic              hit;

   always_comb begin
      prev_d    = cd_input;
      cnt_d     = cnt_q;
      code_d    = code_q;
      confirm_d = 1'b0;
      idle_d    = 1'b0;
      changed   = (cd_input != prev_q);

      if (changed) begin
         cnt_d = CW'(1);
      end else if (cnt_q != DB_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end

      // Fires only on the cycle the count arrives at DEBOUNCE, never while parked there
      hit = (cnt_d == DB_MAX) && (changed || (cnt_q != DB_MAX));

      if (hit) begin
         code_d    = cd_input;
         confirm_d = (cd_input < NC_CODE);
         idle_d    = !(cd_input < NC_CODE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         confirm_q <= 1'b0;
         idle_q    <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         confirm_q <= confirm_d;
         idle_q    <= idle_d;
      end
   end

   assign confirm = confirm_q;
   assign code    = code_q;
   assign idle    = idle_q;

endmodule

// File: rtl/color_report_tx.sv
// Confirmed-colour LED driver and byte-serial report transmitter with a
// one-deep pending slot and saturating drop counter.
//
//   state | meaning
//   IDLE  | no message in flight, tx_valid low
//   SEND  | presenting byte idx of the latched colour's message
module color_report_tx
   import color_pkg::*;
#(
   parameter int                        NUM_COLORS = 3,
   parameter int                        CODE_W     = 2,
   parameter int                        DEBOUNCE   = 5,
   parameter logic [7:0]                UNIT_ID    = 8'h31,
   parameter logic [8*NUM_COLORS-1:0]   LETTERS    = {"W", "N", "P"},
   parameter int                        DROP_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CODE_W-1:0]     cd_input,
   input  logic                  stop,
   output logic [NUM_COLORS-1:0] led,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
   localparam int         NCODES   = 2 ** CODE_W;

   logic              db_confirm;
   logic [CODE_W-1:0] db_code;
   logic              db_idle;

   color_debounce #(
      .CODE_W     (CODE_W),
      .DEBOUNCE   (DEBOUNCE),
      .NUM_COLORS (NUM_COLORS)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .cd_input (cd_input),
      .confirm  (db_confirm),
      .code     (db_code),
      .idle     (db_idle)
   );

   logic [7:0] letter_tab [NCODES];

   for (genvar g = 0; g < NCODES; g++) begin : g_letter
      if (g < NUM_COLORS) begin : g_used
         assign letter_tab[g] = LETTERS[8*g +: 8];
      end else begin : g_unused
         assign letter_tab[g] = ASCII_QM;
      end
   end

   state_t                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [CODE_W-1:0]     color_q, color_d;
   logic                  pend_full_q, pend_full_d;
   logic [CODE_W-1:0]     pend_color_q, pend_color_d;
   logic [DROP_W-1:0]     drop_q, drop_d;
   logic [NUM_COLORS-1:0] led_q, led_d;

   logic color_req;
   logic accept;
   logic last;

   assign color_req = db_confirm && !stop;
   assign accept    = (state_q == SEND) && tx_ready;
   assign last      = accept && (idx_q == LAST_IDX);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      color_d      = color_q;
      pend_full_d  = pend_full_q;
      pend_color_d = pend_color_q;
      drop_d       = drop_q;

      case (state_q)
         IDLE: begin
            if (color_req) begin
               state_d = SEND;
               color_d = db_code;
               idx_d   = 4'd0;
            end
         end
         SEND: begin
            if (accept) begin
               if (!last) begin
                  idx_d = idx_q + 4'd1;
               end else if (pend_full_q) begin
                  color_d     = pend_color_q;
                  idx_d       = 4'd0;
                  pend_full_d = 1'b0;
               end else if (color_req) begin
                  color_d = db_code;
                  idx_d   = 4'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            // A request not absorbed by the end-of-message reload parks in the slot;
            // it only counts as a drop if it displaces a report that stays unsent.
            if (color_req && !(last && !pend_full_q)) begin
               pend_full_d  = 1'b1;
               pend_color_d = db_code;
               if (pend_full_q && !last && (drop_q != '1)) begin
                  drop_d = drop_q + DROP_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      led_d = led_q;
      if (stop) begin
         led_d = '0;
      end else if (color_req) begin
         led_d = NUM_COLORS'(1) << db_code;
      end else if (db_idle) begin
         led_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         color_q      <= '0;
         pend_full_q  <= 1'b0;
         pend_color_q <= '0;
         drop_q       <= '0;
         led_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         color_q      <= color_d;
         pend_full_q  <= pend_full_d;
         pend_color_q <= pend_color_d;
         drop_q       <= drop_d;
         led_q        <= led_d;
      end
   end

   assign tx_valid = (state_q == SEND);
   assign busy     = (state_q != IDLE);
   assign tx_data  = tx_valid ? msg_byte(idx_q, letter_tab[color_q], UNIT_ID) : 8'h00;
   assign led      = led_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_color_report_tx.sv
// Directed self-checking bench for color_report_tx using default parameters.
module tb_color_report_tx;

   logic       clk;
   logic       rst;
   logic [1:0] cd_input;
   logic       stop;
   logic [2:0] led;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic [7:0] drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   color_report_tx dut (
      .clk      (clk),
      .rst      (rst),
      .cd_input (cd_input),
      .stop     (stop),
      .led      (led),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one full message, one byte per cycle; optional stop pulse inside it.
   task automatic send_msg(input string tag, input logic [7:0] letter,
                           input int stop_on, input int stop_off);
      string      base;
      logic [7:0] exp;
      base = "SI-SIM1-x-#";
      for (int i = 0; i < 12; i++) begin
         if (i == stop_on)  stop = 1'b1;
         if (i == stop_off) stop = 1'b0;
         if (i == 11)     exp = 8'h0A;
         else if (i == 8) exp = letter;
         else             exp = base[i];
         chk($sformatf("%s_byte%0d", tag, i), 32'({tx_valid, tx_data}), 32'({1'b1, exp}));
         step();
      end
   endtask

   initial begin
      int cnt_v;
      int cnt_l;
      int bad;

      rst      = 1'b1;
      cd_input = 2'd3;
      stop     = 1'b0;
      tx_ready = 1'b1;
      step();
      step();
      chk("rst_led",      32'(led),      32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_drop",     32'(drop_cnt), 32'd0);
      rst = 1'b0;
      repeat (6) step();

      // 1: colour 0 held, one message, 1-cycle latency after confirm
      cd_input = 2'd0;
      repeat (5) step();
      chk("t1_pre_valid", 32'(tx_valid), 32'd0);
      chk("t1_pre_led",   32'(led),      32'd0);
      step();
      chk("t1_led", 32'(led), 32'b001);
      send_msg("t1", "P", -1, -1);
      chk("t1_end_valid", 32'(tx_valid), 32'd0);
      chk("t1_end_busy",  32'(busy),     32'd0);
      cnt_v = 0;
      repeat (15) begin
         step();
         if (tx_valid) cnt_v++;
      end
      chk("t1_single_report", 32'(cnt_v), 32'd0);

      // idle code confirmed clears led
      cd_input = 2'd3;
      repeat (6) step();
      chk("idle_clears_led", 32'(led), 32'd0);

      // 2: colour 1 only 4 cycles -> never confirmed
      cd_input = 2'd1;
      repeat (4) step();
      cd_input = 2'd3;
      cnt_v = 0;
      cnt_l = 0;
      repeat (10) begin
         step();
         if (tx_valid) cnt_v++;
         if (led != 3'b000) cnt_l++;
      end
      chk("t2_no_valid", 32'(cnt_v), 32'd0);
      chk("t2_no_led",   32'(cnt_l), 32'd0);

      // 3: stalled first byte held stable for 20 cycles
      tx_ready = 1'b0;
      cd_input = 2'd0;
      repeat (6) step();
      chk("t3_first", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h53}));
      bad = 0;
      repeat (20) begin
         step();
         if (!(tx_valid === 1'b1 && tx_data === 8'h53)) bad++;
      end
      chk("t3_hold", 32'(bad), 32'd0);
      tx_ready = 1'b1;
      send_msg("t3", "P", -1, -1);
      chk("t3_end_valid", 32'(tx_valid), 32'd0);

      // 4: confirms 0,1,2 during one stalled message
      tx_ready = 1'b0;
      cd_input = 2'd3;
      repeat (6) step();
      cd_input = 2'd0;
      repeat (6) step();
      chk("t4_first", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h53}));
      cd_input = 2'd1;
      repeat (6) step();
      chk("t4_drop_after1", 32'(drop_cnt), 32'd0);
      cd_input = 2'd2;
      repeat (6) step();
      chk("t4_drop_after2", 32'(drop_cnt), 32'd1);
      chk("t4_led",         32'(led),      32'b100);
      chk("t4_still_S",     32'(tx_data),  32'h53);
      tx_ready = 1'b1;
      send_msg("t4a", "P", -1, -1);
      send_msg("t4b", "W", -1, -1);
      chk("t4_end_valid", 32'(tx_valid), 32'd0);
      chk("t4_end_drop",  32'(drop_cnt), 32'd1);

      // 5: stop during confirm blocks the report; stop mid-message does not
      cd_input = 2'd3;
      repeat (6) step();
      chk("t5_led_cleared", 32'(led), 32'd0);
      stop     = 1'b1;
      cd_input = 2'd2;
      cnt_v = 0;
      cnt_l = 0;
      repeat (7) begin
         step();
         if (tx_valid) cnt_v++;
         if (led != 3'b000) cnt_l++;
      end
      stop = 1'b0;
      repeat (5) begin
         step();
         if (tx_valid) cnt_v++;
      end
      chk("t5_stop_no_msg", 32'(cnt_v), 32'd0);
      chk("t5_stop_no_led", 32'(cnt_l), 32'd0);
      cd_input = 2'd1;
      repeat (6) step();
      chk("t5_led_n", 32'(led), 32'b010);
      send_msg("t5", "N", 3, 5);
      chk("t5_led_after_stop", 32'(led),      32'd0);
      chk("t5_end_valid",      32'(tx_valid), 32'd0);

      // 6: reset in the middle of a message
      cd_input = 2'd0;
      repeat (6) step();
      for (int i = 0; i < 5; i++) step();
      chk("t6_byte5", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h4D}));
      rst = 1'b1;
      step();
      chk("t6_valid", 32'(tx_valid), 32'd0);
      chk("t6_busy",  32'(busy),     32'd0);
      chk("t6_drop",  32'(drop_cnt), 32'd0);
      chk("t6_led",   32'(led),      32'd0);
      chk("t6_data",  32'(tx_data),  32'd0);
      rst = 1'b0;
      step();
      chk("t6_post_valid", 32'(tx_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
